// File: rtl/jpeg_pkg.sv
// Purpose: shared constants for the JPEG entropy front end (FSM encoding, marker bytes, default window).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package jpeg_pkg;

    // Default bit-window width presented to the Huffman decoder.
    localparam int JPEG_WIN = 32;

    // Byte-reader state encoding.
    localparam logic [1:0] S_DATA = 2'd0;  // normal entropy-coded data
    localparam logic [1:0] S_FF   = 2'd1;  // an FF byte has been popped and is held
    localparam logic [1:0] S_MARK = 2'd2;  // marker pending, loading stalled

    // Marker bytes (second byte after the FF prefix).
    localparam logic [7:0] MK_RST0   = 8'hD0;
    localparam logic [7:0] MK_RST1   = 8'hD1;
    localparam logic [7:0] MK_RST2   = 8'hD2;
    localparam logic [7:0] MK_RST3   = 8'hD3;
    localparam logic [7:0] MK_RST4   = 8'hD4;
    localparam logic [7:0] MK_RST5   = 8'hD5;
    localparam logic [7:0] MK_RST6   = 8'hD6;
    localparam logic [7:0] MK_RST7   = 8'hD7;
    localparam logic [7:0] MK_EOI    = 8'hD9;
    localparam logic [7:0] MK_STUFF  = 8'h00;
    localparam logic [7:0] MK_PREFIX = 8'hFF;

endpackage

// File: rtl/jpeg_bit_reader.sv
// Purpose: pops bytes from a show-ahead FIFO, strips FF00 stuffing / FF fill, stalls on markers,
//          and presents an MSB-aligned bit window that the Huffman decoder consumes 1..MAXC bits at a time.
// Latency: a byte popped in cycle N is visible in peek/bits_avail in cycle N+1; err is registered (+1).
// Backpressure: pops only while the window has room for a whole byte and no marker is pending.
// Ports: fifo_dout/fifo_empty/fifo_rd - upstream show-ahead FIFO; peek/bits_avail - bit window;
//        consume/consume_len/align - window consumption; marker_valid/marker_code/marker_ack - marker
//        stall handshake; err - pulse when an illegal consume is ignored.
module jpeg_bit_reader
    import jpeg_pkg::*;
#(
    parameter int WIN  = JPEG_WIN,
    parameter int MAXC = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               fifo_dout,
    input  logic                     fifo_empty,
    output logic                     fifo_rd,
    output logic [WIN-1:0]           peek,
    output logic [$clog2(WIN+1)-1:0] bits_avail,
    input  logic                     consume,
    input  logic [4:0]               consume_len,
    input  logic                     align,
    output logic                     marker_valid,
    output logic [7:0]               marker_code,
    input  logic                     marker_ack,
    output logic                     err
);

    localparam int AW = $clog2(WIN+1);
    localparam logic [AW-1:0] MAXC_W    = AW'(MAXC);
    localparam logic [AW-1:0] ROOM_LIM  = AW'(WIN-8);
    localparam logic [AW-1:0] BYTE_BITS = AW'(8);

    logic [1:0]     state_q, state_d;
    logic [WIN-1:0] win_q, win_d;
    logic [AW-1:0]  avail_q, avail_d;
    logic [7:0]     code_q, code_d;
    logic           err_q, err_d;

    logic [AW-1:0]  len_ext;
    logic           len_ok;
    logic [AW-1:0]  shamt;
    logic [WIN-1:0] win_sh;
    logic [AW-1:0]  avail_sh;
    logic           app;
    logic [7:0]     app_byte;

    // Pop only from registered state: room for a full byte (checked before this
    // cycle's consume) and not stalled behind a marker.
    assign fifo_rd = !fifo_empty && (state_q != S_MARK) && (avail_q <= ROOM_LIM);

    assign len_ext = AW'(consume_len);
    assign len_ok  = (consume_len != 5'd0) && (len_ext <= MAXC_W) && (len_ext <= avail_q);

    always_comb begin
        shamt    = '0;
        err_d    = 1'b0;
        app      = 1'b0;
        app_byte = fifo_dout;
        state_d  = state_q;
        code_d   = code_q;

        // Consume takes priority over align; align drops the partial byte.
        if (consume) begin
            if (len_ok) begin
                shamt = len_ext;
            end else begin
                err_d = 1'b1;
            end
        end else if (align) begin
            shamt = {{(AW-3){1'b0}}, avail_q[2:0]};
        end

        win_sh   = win_q << shamt;
        avail_sh = avail_q - shamt;

        if (fifo_rd) begin
            case (state_q)
                S_DATA: begin
                    if (fifo_dout == MK_PREFIX) begin
                        state_d = S_FF;
                    end else begin
                        app = 1'b1;
                    end
                end
                S_FF: begin
                    if (fifo_dout == MK_STUFF) begin
                        // Stuffed zero: the held FF is real data.
                        app      = 1'b1;
                        app_byte = MK_PREFIX;
                        state_d  = S_DATA;
                    end else if (fifo_dout != MK_PREFIX) begin
                        // FF FF is fill and keeps us in S_FF; anything else is a marker.
                        code_d  = fifo_dout;
                        state_d = S_MARK;
                    end
                end
                default: begin
                end
            endcase
        end

        if ((state_q == S_MARK) && marker_ack) begin
            state_d = S_DATA;
        end

        // Append lands directly under the bits that survive this cycle's consume.
        win_d   = win_sh;
        avail_d = avail_sh;
        if (app) begin
            win_d   = win_sh | ({app_byte, {(WIN-8){1'b0}}} >> avail_sh);
            avail_d = avail_sh + BYTE_BITS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_DATA;
            win_q   <= '0;
            avail_q <= '0;
            code_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            avail_q <= avail_d;
            code_q  <= code_d;
            err_q   <= err_d;
        end
    end

    assign peek         = win_q;
    assign bits_avail   = avail_q;
    assign marker_valid = (state_q == S_MARK);
    assign marker_code  = code_q;
    assign err          = err_q;

endmodule

// File: tb/tb_jpeg_bit_reader.sv
// Purpose: self-checking bench for jpeg_bit_reader against a bit-queue reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_jpeg_bit_reader;

    localparam int WIN = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [7:0]     fifo_dout;
    logic           fifo_empty;
    logic           fifo_rd;
    logic [WIN-1:0] peek;
    logic [5:0]     bits_avail;
    logic           consume;
    logic [4:0]     consume_len;
    logic           align;
    logic           marker_valid;
    logic [7:0]     marker_code;
    logic           marker_ack;
    logic           err;

    jpeg_bit_reader #(.WIN(WIN), .MAXC(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_dout    (fifo_dout),
        .fifo_empty   (fifo_empty),
        .fifo_rd      (fifo_rd),
        .peek         (peek),
        .bits_avail   (bits_avail),
        .consume      (consume),
        .consume_len  (consume_len),
        .align        (align),
        .marker_valid (marker_valid),
        .marker_code  (marker_code),
        .marker_ack   (marker_ack),
        .err          (err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: upstream FIFO contents, destuffed bit stream, marker flags.
    logic [7:0] fq[$];
    bit         bq[$];
    bit         m_ff;
    bit         m_mark;
    bit         m_err;
    logic [7:0] m_code;

    task automatic model_reset();
        bq.delete();
        m_ff   = 0;
        m_mark = 0;
        m_err  = 0;
        m_code = 8'h00;
    endtask

    task automatic push_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) bq.push_back(b[i]);
    endtask

    function automatic logic [WIN-1:0] exp_peek();
        logic [WIN-1:0] r;
        r = '0;
        for (int i = 0; i < WIN && i < bq.size(); i++) r[WIN-1-i] = bq[i];
        return r;
    endfunction

    // One clock cycle: drive inputs, check pop decision, advance model, check registered outputs.
    task automatic cycle(input bit c, input int len, input bit a, input bit k);
        bit         exp_rd;
        int         sh;
        logic [7:0] b;
        consume     = c;
        consume_len = 5'(len);
        align       = a;
        marker_ack  = k;
        fifo_empty  = (fq.size() == 0);
        fifo_dout   = (fq.size() == 0) ? 8'h00 : fq[0];
        #1;
        exp_rd = (fq.size() != 0) && !m_mark && (bq.size() <= WIN - 8);
        chk("fifo_rd", fifo_rd, exp_rd);

        sh    = 0;
        m_err = 0;
        if (c) begin
            if (len >= 1 && len <= 16 && len <= bq.size()) sh = len;
            else m_err = 1;
        end else if (a) begin
            sh = bq.size() % 8;
        end
        repeat (sh) void'(bq.pop_front());
        if (k && m_mark) m_mark = 0;
        if (exp_rd) begin
            b = fq.pop_front();
            if (!m_ff) begin
                if (b == 8'hFF) m_ff = 1;
                else push_bits(b);
            end else if (b == 8'h00) begin
                push_bits(8'hFF);
                m_ff = 0;
            end else if (b != 8'hFF) begin
                m_mark = 1;
                m_code = b;
                m_ff   = 0;
            end
        end

        @(posedge clk);
        #1;
        chk("peek", peek, exp_peek());
        chk("bits_avail", bits_avail, bq.size());
        chk("marker_valid", marker_valid, m_mark);
        chk("marker_code", marker_code, m_code);
        chk("err", err, m_err);
        consume    = 0;
        align      = 0;
        marker_ack = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && bq.size() != 0; i++)
            cycle(1, (bq.size() < 16) ? bq.size() : 16, 0, 0);
    endtask

    task automatic feed_random();
        int r;
        logic [7:0] b;
        r = $urandom_range(0, 99);
        b = 8'($urandom);
        if (r < 12) begin
            fq.push_back(8'hFF);
            case ($urandom_range(0, 3))
                0:       fq.push_back(8'h00);
                1:       fq.push_back(8'hFF);
                2:       fq.push_back(8'hD0 + 8'($urandom_range(0, 7)));
                default: fq.push_back(8'hD9);
            endcase
        end else begin
            fq.push_back(b);
        end
    endtask

    logic [3:0] nib[4];

    initial begin
        rst         = 1'b1;
        fifo_dout   = 8'h00;
        fifo_empty  = 1'b1;
        consume     = 1'b0;
        consume_len = 5'd0;
        align       = 1'b0;
        marker_ack  = 1'b0;
        model_reset();
        #2;
        chk("rst_peek", peek, 0);
        chk("rst_avail", bits_avail, 0);
        chk("rst_mv", marker_valid, 0);
        chk("rst_code", marker_code, 0);
        chk("rst_err", err, 0);
        chk("rst_rd", fifo_rd, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // A5 3C consumed as four nibbles.
        nib[0] = 4'hA; nib[1] = 4'h5; nib[2] = 4'h3; nib[3] = 4'hC;
        fq.push_back(8'hA5);
        fq.push_back(8'h3C);
        repeat (3) cycle(0, 0, 0, 0);
        chk("t1_avail16", bits_avail, 16);
        for (int i = 0; i < 4; i++) begin
            chk("t1_nibble", peek[31:28], nib[i]);
            cycle(1, 4, 0, 0);
        end
        chk("t1_avail0", bits_avail, 0);
        chk("t1_err", err, 0);

        // FF 00 12: stuffed FF then 12.
        fq.push_back(8'hFF);
        fq.push_back(8'h00);
        fq.push_back(8'h12);
        repeat (4) cycle(0, 0, 0, 0);
        chk("t2_avail", bits_avail, 16);
        chk("t2_ff", peek[31:24], 8'hFF);
        cycle(1, 8, 0, 0);
        chk("t2_12", peek[31:24], 8'h12);
        cycle(1, 8, 0, 0);
        chk("t2_nomark", marker_valid, 0);

        // 81 FF FF D3 55: marker stall, 55 held until after ack.
        fq.push_back(8'h81);
        fq.push_back(8'hFF);
        fq.push_back(8'hFF);
        fq.push_back(8'hD3);
        fq.push_back(8'h55);
        repeat (5) cycle(0, 0, 0, 0);
        chk("t3_mv", marker_valid, 1);
        chk("t3_code", marker_code, 8'hD3);
        chk("t3_avail", bits_avail, 8);
        chk("t3_stall_rd", fifo_rd, 0);
        cycle(1, 4, 0, 0);
        chk("t3_consume_in_mark", bits_avail, 4);
        cycle(0, 0, 0, 1);
        chk("t3_ack_mv", marker_valid, 0);
        chk("t3_ack_avail", bits_avail, 4);
        cycle(0, 0, 0, 0);
        chk("t3_55_avail", bits_avail, 12);
        chk("t3_55", peek[27:20], 8'h55);
        drain();

        // Align with 11 bits, then align+consume together.
        fq.push_back(8'hC3);
        fq.push_back(8'h5A);
        repeat (3) cycle(0, 0, 0, 0);
        cycle(1, 5, 0, 0);
        chk("t4_avail11", bits_avail, 11);
        cycle(0, 0, 1, 0);
        chk("t4_align_avail", bits_avail, 8);
        chk("t4_align_byte", peek[31:24], 8'h5A);
        cycle(1, 3, 1, 0);
        chk("t4_cons_wins", bits_avail, 5);
        drain();

        // Illegal consumes: too long, and zero length.
        fq.push_back(8'h96);
        repeat (2) cycle(0, 0, 0, 0);
        cycle(1, 12, 0, 0);
        chk("t5_err_long", err, 1);
        chk("t5_avail", bits_avail, 8);
        chk("t5_byte", peek[31:24], 8'h96);
        cycle(0, 0, 0, 0);
        chk("t5_err_pulse", err, 0);
        cycle(1, 0, 0, 0);
        chk("t5_err_zero", err, 1);
        cycle(0, 0, 0, 0);
        chk("t5_err_clear", err, 0);
        drain();

        // Full FIFO with continuous 16-bit consumes.
        for (int i = 0; i < 48; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            fq.push_back(b);
            if (b == 8'hFF) fq.push_back(8'h00);
        end
        for (int i = 0; i < 2000 && (fq.size() != 0 || bq.size() >= 16); i++) begin
            cycle(bq.size() >= 16, 16, 0, 0);
            chk("avail_max", bits_avail > 6'd32, 0);
        end
        drain();

        // Random mix of stuffing, fill, markers, acks, aligns and illegal consumes.
        for (int i = 0; i < 400; i++) begin
            if (fq.size() < 4) feed_random();
            cycle($urandom_range(0, 2) != 0, $urandom_range(0, 20),
                  $urandom_range(0, 7) == 0,
                  m_mark ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0));
        end

        // Reset asserted mid-stream clears everything at once.
        fq.delete();
        fifo_empty = 1'b1;
        fifo_dout  = 8'h00;
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_peek", peek, 0);
        chk("mrst_avail", bits_avail, 0);
        chk("mrst_mv", marker_valid, 0);
        chk("mrst_code", marker_code, 0);
        chk("mrst_err", err, 0);
        chk("mrst_rd", fifo_rd, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        fq.push_back(8'h5A);
        repeat (2) cycle(0, 0, 0, 0);
        chk("post_rst_byte", peek[31:24], 8'h5A);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
